// File: rtl/sram_mem_responder.sv
// Mem-stage memory responder: each 32-bit word access runs as two timed 16-bit SRAM phases.
// Optional feature macro: SRAM_READ_HIT_EN (same-cycle reply for a repeated read of the last word read).
module sram_mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          SRAM_ADDR_W = 18,
    parameter int          T_PHASE     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          WORD_W   = SRAM_ADDR_W - 1;
    localparam logic [3:0]  LAST_CNT = 4'(T_PHASE - 1);

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic                   r_op_wr;
    logic [WORD_W-1:0]      r_word;
    logic [31:0]            r_wdata;
    logic [31:0]            r_read_data;
    logic [SRAM_ADDR_W-1:0] r_sram_addr;
    logic                   r_we_n;
    logic                   r_dq_oe;
    logic [15:0]            r_dq_out;

    state_t                 w_nxt_state;
    logic [3:0]             w_nxt_cnt;
    logic                   w_nxt_wr;
    logic [WORD_W-1:0]      w_nxt_word;
    logic [31:0]            w_nxt_wdata;
    logic [31:0]            w_diff;
    logic [WORD_W-1:0]      w_word;
    logic                   w_req;
    logic                   w_hit;
    logic                   w_start;
    logic                   w_last;
    logic [SRAM_ADDR_W-1:0] w_bus_addr;
    logic                   w_bus_we_n;
    logic                   w_bus_oe;
    logic [15:0]            w_bus_dq;
    logic                   w_unused;

    // Only the word bits that reach the SRAM address matter; higher bits alias.
    assign w_diff   = address - ADDR_BASE;
    assign w_word   = w_diff[SRAM_ADDR_W:2];
    assign w_unused = ^{w_diff[1:0], w_diff[31:SRAM_ADDR_W+1]};
    assign w_req    = rd_en | wr_en;
    assign w_last   = (r_cnt == LAST_CNT);

`ifdef SRAM_READ_HIT_EN
    logic              r_hit_valid;
    logic [WORD_W-1:0] r_hit_word;

    assign w_hit = (r_state == ST_IDLE) & rd_en & ~wr_en & r_hit_valid & (w_word == r_hit_word);

    // Tracks the word of the last completed read; any write start invalidates it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_valid <= 1'b0;
            r_hit_word  <= '0;
        end else if (w_start & wr_en) begin
            r_hit_valid <= 1'b0;
        end else if ((r_state == ST_HI) & w_last & ~r_op_wr) begin
            r_hit_valid <= 1'b1;
            r_hit_word  <= r_word;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    assign w_start = (r_state == ST_IDLE) & w_req & ~w_hit;
    assign ready   = (r_state == ST_DONE) | ((r_state == ST_IDLE) & (~w_req | w_hit));

    // Next-state and phase-counter logic; the op is latched only when leaving IDLE.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_nxt_state = ST_LO;
                    w_nxt_cnt   = 4'd0;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_LO: begin
                if (w_last) begin
                    w_nxt_state = ST_HI;
                    w_nxt_cnt   = 4'd0;
                end else begin
                    w_nxt_cnt = r_cnt + 4'd1;
                end
            end
            ST_HI: begin
                if (w_last) begin
                    w_nxt_state = ST_DONE;
                    w_nxt_cnt   = 4'd0;
                end else begin
                    w_nxt_cnt = r_cnt + 4'd1;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = 4'd0;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = 4'd0;
            end
        endcase
        w_nxt_wr    = w_start ? wr_en      : r_op_wr;
        w_nxt_word  = w_start ? w_word     : r_word;
        w_nxt_wdata = w_start ? write_data : r_wdata;
    end

    // Bus values for the coming cycle, so the registered bus lines up with the state.
    always_comb begin
        w_bus_addr = '0;
        w_bus_we_n = 1'b1;
        w_bus_oe   = 1'b0;
        w_bus_dq   = 16'h0000;
        case (w_nxt_state)
            ST_LO: begin
                w_bus_addr = {w_nxt_word, 1'b0};
                w_bus_oe   = w_nxt_wr;
                w_bus_dq   = w_nxt_wr ? w_nxt_wdata[15:0] : 16'h0000;
                w_bus_we_n = ~(w_nxt_wr & (w_nxt_cnt != LAST_CNT));
            end
            ST_HI: begin
                w_bus_addr = {w_nxt_word, 1'b1};
                w_bus_oe   = w_nxt_wr;
                w_bus_dq   = w_nxt_wr ? w_nxt_wdata[31:16] : 16'h0000;
                w_bus_we_n = ~(w_nxt_wr & (w_nxt_cnt != LAST_CNT));
            end
            default: begin
                w_bus_addr = '0;
                w_bus_we_n = 1'b1;
                w_bus_oe   = 1'b0;
                w_bus_dq   = 16'h0000;
            end
        endcase
    end

    // FSM state, latched op and registered SRAM bus; read halves captured on each phase's last cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_op_wr     <= 1'b0;
            r_word      <= '0;
            r_wdata     <= 32'h0000_0000;
            r_read_data <= 32'h0000_0000;
            r_sram_addr <= '0;
            r_we_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= 16'h0000;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_op_wr     <= w_nxt_wr;
            r_word      <= w_nxt_word;
            r_wdata     <= w_nxt_wdata;
            r_sram_addr <= w_bus_addr;
            r_we_n      <= w_bus_we_n;
            r_dq_oe     <= w_bus_oe;
            r_dq_out    <= w_bus_dq;
            if ((r_state == ST_LO) & w_last & ~r_op_wr) begin
                r_read_data[15:0] <= sram_dq_in;
            end else if ((r_state == ST_HI) & w_last & ~r_op_wr) begin
                r_read_data[31:16] <= sram_dq_in;
            end
        end
    end

    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_we_n   = r_we_n;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: cycle-offset reference model, small SRAM emulation, directed and random ops.
module tb_sram_mem_responder;
    localparam int          T    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = 32'h0, write_data = 32'h0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    always #5 clk = ~clk;

    sram_mem_responder #(.ADDR_BASE(BASE), .SRAM_ADDR_W(18), .T_PHASE(T)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
    );

    function automatic logic [15:0] init_val(int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // SRAM emulation, indexed by the low 8 address bits; reloads its pattern on reset.
    logic [15:0] smem [0:255];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) smem[i] <= init_val(i);
        end else if (!sram_we_n) begin
            smem[sram_addr[7:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in = smem[sram_addr[7:0]];

    // Reference model state
    bit          m_busy;
    int          m_k;
    bit          m_wr;
    logic [31:0] m_word, m_wdata, m_rdata;
    logic [15:0] mref [0:255];
    bit          m_valid;
    logic [31:0] m_hit_word;
    logic        e_ready, e_we_n, e_oe, e_rd_chk;
    logic [17:0] e_addr;
    logic [15:0] e_dq;

    int n_checks = 0, n_pass = 0;
    int lows, cap_act, cap_wen;
    logic [17:0] cap_lo_addr, cap_hi_addr;
    logic [15:0] cap_lo_dq, cap_hi_dq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [17:0] hw_addr(logic [31:0] word, bit hi);
        return 18'({word[30:0], hi});
    endfunction

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_rdata = 32'h0; m_valid = 0; m_hit_word = 32'h0;
        for (int i = 0; i < 256; i++) mref[i] = init_val(i);
    endtask

    // Expected outputs for the current cycle, from the op's cycle offset since it was first seen.
    task automatic model_cycle();
        bit hit, hi;
        int idx;
        logic [17:0] a_lo, a_hi;
        hit = 0;
`ifdef SRAM_READ_HIT_EN
        hit = !m_busy && rd_en && !wr_en && m_valid && (((address - BASE) >> 2) == m_hit_word);
`endif
        e_ready = 0; e_addr = 18'h0; e_we_n = 1; e_oe = 0; e_dq = 16'h0; e_rd_chk = 0;
        if (!m_busy) begin
            e_rd_chk = 1;
            if (hit || !(rd_en || wr_en)) begin
                e_ready = 1;
            end else begin
                m_busy = 1; m_k = 0; m_wr = wr_en;
                m_word = (address - BASE) >> 2; m_wdata = write_data;
                if (wr_en) m_valid = 0;
            end
        end else begin
            m_k++;
            if (m_k <= 2 * T) begin
                hi     = (m_k > T);
                idx    = hi ? m_k - T - 1 : m_k - 1;
                e_addr = hw_addr(m_word, hi);
                e_oe   = m_wr;
                e_dq   = hi ? m_wdata[31:16] : m_wdata[15:0];
                e_we_n = !(m_wr && idx != T - 1);
            end else begin
                e_ready = 1; e_rd_chk = 1; m_busy = 0;
                a_lo = hw_addr(m_word, 0);
                a_hi = hw_addr(m_word, 1);
                if (m_wr) begin
                    mref[a_lo[7:0]] = m_wdata[15:0];
                    mref[a_hi[7:0]] = m_wdata[31:16];
                end else begin
                    m_rdata = {mref[a_hi[7:0]], mref[a_lo[7:0]]};
                    m_valid = 1; m_hit_word = m_word;
                end
            end
        end
    endtask

    task automatic compare_cycle();
        chk("ready", {31'h0, ready}, {31'h0, e_ready});
        chk("sram_addr", {14'h0, sram_addr}, {14'h0, e_addr});
        chk("sram_we_n", {31'h0, sram_we_n}, {31'h0, e_we_n});
        chk("sram_dq_oe", {31'h0, sram_dq_oe}, {31'h0, e_oe});
        if (e_oe) chk("sram_dq_out", {16'h0, sram_dq_out}, {16'h0, e_dq});
        if (e_rd_chk) chk("read_data", read_data, m_rdata);
    endtask

    task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        model_cycle();
        @(negedge clk);
        compare_cycle();
    endtask

    // Holds a request until the model says it has completed, recording bus activity.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bit done, got_lo;
        done = 0; got_lo = 0; lows = 0; cap_act = 0; cap_wen = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            step(rd, wr, a, d);
            if (!ready) lows++;
            if (sram_addr != 18'h0) cap_act++;
            if (!sram_we_n) cap_wen++;
            if (sram_dq_oe) begin
                if (!got_lo) begin cap_lo_addr = sram_addr; cap_lo_dq = sram_dq_out; got_lo = 1; end
                cap_hi_addr = sram_addr; cap_hi_dq = sram_dq_out;
            end
            if (e_ready && !m_busy) done = 1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL op_timeout: no completion within 60 cycles at %0t", $time);
        end
    endtask

    initial begin
        logic r, w;
        int   sel;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_sram_addr", {14'h0, sram_addr}, 32'h0);

        run_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        chk("wr_stall_cycles", lows, 5);
        chk("wr_lo_addr", {14'h0, cap_lo_addr}, 32'd2);
        chk("wr_lo_dq", {16'h0, cap_lo_dq}, 32'hBEEF);
        chk("wr_hi_addr", {14'h0, cap_hi_addr}, 32'd3);
        chk("wr_hi_dq", {16'h0, cap_hi_dq}, 32'hDEAD);
        chk("wr_we_low_cycles", cap_wen, 2);

        run_op(1'b1, 1'b0, 32'd1028, 32'h0);
        chk("rd_stall_cycles", lows, 5);
        chk("rd_data", read_data, 32'hDEADBEEF);

        run_op(1'b1, 1'b1, 32'd1032, 32'h12345678);
        chk("both_lo_addr", {14'h0, cap_lo_addr}, 32'd4);
        chk("both_hi_addr", {14'h0, cap_hi_addr}, 32'd5);
        chk("both_read_data_kept", read_data, 32'hDEADBEEF);

`ifdef SRAM_READ_HIT_EN
        run_op(1'b1, 1'b0, 32'd1028, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        run_op(1'b1, 1'b0, 32'd1028, 32'h0);
        chk("hit_stall_cycles", lows, 0);
        chk("hit_bus_activity", cap_act, 0);
        run_op(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        run_op(1'b1, 1'b0, 32'd1028, 32'h0);
        chk("after_wr_stall_cycles", lows, 5);
`endif

        // Reset during the first HI cycle of a write
        step(1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < T + 2; c++) step(1'b0, 1'b1, 32'd1040, 32'hA5A5_1234);
        rd_en = 1'b0; wr_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("arst_we_n", {31'h0, sram_we_n}, 32'h1);
        chk("arst_oe", {31'h0, sram_dq_oe}, 32'h0);
        chk("arst_addr", {14'h0, sram_addr}, 32'h0);
        chk("arst_read_data", read_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("post_rst_ready", {31'h0, ready}, 32'h1);

        // Random traffic; inputs are junk while an op is in flight
        for (int c = 0; c < 600; c++) begin
            if (!m_busy) begin
                sel = $urandom_range(0, 9);
                r = (sel >= 4 && sel <= 6) || sel == 9;
                w = (sel == 7 || sel == 8 || sel == 9);
                if ($urandom_range(0, 15) == 0) step(r, w, $urandom(), $urandom());
                else step(r, w, BASE + 32'(4 * $urandom_range(0, 40)), $urandom());
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
